// File: rtl/demux1x4_stream_pkg.sv
// Channel codes and slot state encoding shared by the 1x4 stream demux
// and its 4x1 mux counterpart.
package demux1x4_stream_pkg;

  typedef enum logic [1:0] {
    CH_A = 2'b00,
    CH_B = 2'b01,
    CH_C = 2'b10,
    CH_D = 2'b11
  } ch_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/demux1x4_stream_if.sv
// Upstream word/route handshake plus four downstream channels and the counter read port.
// slave = demux side, master = the surrounding producer/consumer side.
interface demux1x4_stream_if #(
  parameter int DATAWIDTH = 4
);

  logic [DATAWIDTH-1:0] IN_DATA;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           slc;

  logic [DATAWIDTH-1:0] OUT_A;
  logic [DATAWIDTH-1:0] OUT_B;
  logic [DATAWIDTH-1:0] OUT_C;
  logic [DATAWIDTH-1:0] OUT_D;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;

  logic [1:0]           cnt_sel;
  logic [7:0]           cnt;

  modport slave (
    input  IN_DATA, in_valid, slc, out_ready, cnt_sel,
    output in_ready, OUT_A, OUT_B, OUT_C, OUT_D, out_valid, cnt
  );

  modport master (
    output IN_DATA, in_valid, slc, out_ready, cnt_sel,
    input  in_ready, OUT_A, OUT_B, OUT_C, OUT_D, out_valid, cnt
  );

endinterface

// File: rtl/demux1x4_stream_slot.sv
// One-entry holding register with EMPTY/FULL state and a wrapping drain counter.
// Latency 1 cycle; a same-cycle drain and load keeps the slot FULL with no bubble.
module demux_slot
  import demux1x4_stream_pkg::*;
#(
  parameter int DATAWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DATAWIDTH-1:0] data_i,
  input  logic                 out_ready_i,
  output logic [DATAWIDTH-1:0] data_o,
  output logic                 valid_o,
  output logic [CNT_W-1:0]     cnt_o
);

  slot_state_e          state_q, state_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drain;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    drain   = (state_q == ST_FULL) && out_ready_i;

    if (load_i) data_d = data_i;
    if (drain)  cnt_d  = cnt_q + CNT_W'(1);

    case (state_q)
      ST_EMPTY: if (load_i)           state_d = ST_FULL;
      ST_FULL:  if (drain && !load_i) state_d = ST_EMPTY;
      default:                        state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == ST_FULL);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux1x4_stream.sv
// Routes one upstream word per cycle to channel slc; latency 1 cycle.
// in_ready follows the selected channel only, including its same-cycle drain.
module demux1x4_stream
  import demux1x4_stream_pkg::*;
#(
  parameter int DATAWIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  demux1x4_stream_if.slave   bus
);

  logic [DATAWIDTH-1:0] dout    [NUM_CH];
  logic [CNT_W-1:0]     cnt_arr [NUM_CH];
  logic [NUM_CH-1:0]    valid;
  logic [NUM_CH-1:0]    load;
  ch_e                  sel_ch;
  logic                 accept;

  assign sel_ch      = ch_e'(bus.slc);
  assign bus.in_ready = !valid[sel_ch] || bus.out_ready[sel_ch];
  assign accept      = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign load[i] = accept && (bus.slc == 2'(i));

    demux_slot #(
      .DATAWIDTH (DATAWIDTH)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load[i]),
      .data_i      (bus.IN_DATA),
      .out_ready_i (bus.out_ready[i]),
      .data_o      (dout[i]),
      .valid_o     (valid[i]),
      .cnt_o       (cnt_arr[i])
    );
  end

  assign bus.OUT_A     = dout[CH_A];
  assign bus.OUT_B     = dout[CH_B];
  assign bus.OUT_C     = dout[CH_C];
  assign bus.OUT_D     = dout[CH_D];
  assign bus.out_valid = valid;
  assign bus.cnt       = cnt_arr[bus.cnt_sel];

endmodule

// File: doc/demux1x4_stream.md
DEMUX1X4_STREAM -- requirements
Module: demux1x4_stream

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 4, giving the width of the data word on every channel.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have port IN_DATA, input, DATAWIDTH bits: the upstream data word.
REQ-005 The module SHALL have port in_valid, input, 1 bit: IN_DATA and slc are valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the module accepts the word this cycle.
REQ-007 The module SHALL have port slc, input, 2 bits: destination channel (00=A, 01=B, 10=C, 11=D).
REQ-008 The module SHALL have ports OUT_A, OUT_B, OUT_C and OUT_D, output, DATAWIDTH bits each: the held word of each channel.
REQ-009 The module SHALL have port out_valid, output, 4 bits: bit i is set while channel i (0=A..3=D) holds a word.
REQ-010 The module SHALL have port out_ready, input, 4 bits: bit i means the channel i consumer takes the word this cycle.
REQ-011 The module SHALL have port cnt_sel, input, 2 bits: selects which channel counter drives cnt.
REQ-012 The module SHALL have port cnt, output, 8 bits: the delivered-word count of the channel chosen by cnt_sel (combinational read).

Function
REQ-013 A transfer SHALL occur on a rising edge when in_valid && in_ready; slc SHALL be sampled only at that edge.
REQ-014 Each channel SHALL implement a 2-state FSM, EMPTY -> FULL on accept, FULL -> EMPTY on drain (out_valid[i] && out_ready[i]) with no simultaneous accept.
REQ-015 The module SHALL drive in_ready = !out_valid[slc] || out_ready[slc], combinationally, with the same-cycle drain pass-through.
REQ-016 Latency SHALL be one cycle: a word accepted at edge k SHALL appear on OUT_x with out_valid[x]=1 immediately after edge k.
REQ-017 When a channel is FULL and out_ready is low, its OUT_x SHALL hold stable and out_valid SHALL stay 1.
REQ-018 On a simultaneous accept and drain of the same channel, the register SHALL load the new word and out_valid SHALL stay 1, with no bubble.
REQ-019 A drain on one channel SHALL be independent of accepts on other channels; all four channels MAY drain in the same cycle.
REQ-020 When a channel is EMPTY, OUT_x SHALL retain its last value (don't-care to consumers); out_ready on an EMPTY channel SHALL have no effect.
REQ-021 A change of slc while in_valid && !in_ready SHALL be legal, SHALL lose no word and SHALL create no duplicate; routing SHALL follow slc at the accepting edge.
REQ-022 Each channel SHALL count drains in an 8-bit counter that wraps from 255 to 0.
REQ-023 The module SHALL drop no word, duplicate no word and reorder no word within a channel under any out_ready pattern.

Reset
REQ-024 While reset=1 at a rising edge, all channels SHALL go EMPTY, out_valid SHALL be 4'b0000, OUT_A..OUT_D SHALL be 0 and all counters SHALL be 0.
REQ-025 Reset SHALL take priority over a simultaneous accept or drain; a word offered in the reset cycle SHALL be discarded.
REQ-026 Reset asserted mid-operation SHALL discard held words; in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-027 Channel codes CH_A..CH_D (2'b00..2'b11) and FSM encodings ST_EMPTY/ST_FULL SHALL live in a shared include file used by this block and its mux4x1 counterpart.
REQ-028 A sub-module demux_slot (one-entry holding register, FSM and 8-bit counter) SHALL be instantiated four times; the top level SHALL hold only the routing and in_ready logic.

Verification
REQ-029 The bench SHALL cover routing: with out_ready=4'hF, send 4'h1,4'h2,4'h3,4'h4 with slc 0,1,2,3 on consecutive cycles -> each OUT_x shows its word one cycle later and cnt for every channel reads 1.
REQ-030 The bench SHALL cover backpressure: with out_ready[1]=0, send 4'hA then 4'hB to channel B -> in_ready=0 on the second word and OUT_B=4'hA stays stable; after out_ready[1]=1, 4'hB is delivered next.
REQ-031 The bench SHALL cover back-to-back streaming: channel C FULL with out_ready[2]=1 and a continuous stream 4'h5,4'h6,4'h7 -> in_ready stays 1, out_valid[2] never drops and the words arrive in order.
REQ-032 The bench SHALL cover slc switching: while channel D is blocked, change slc from 3 to 0 with in_valid held -> the word goes to A on the next edge and D's count is unchanged.
REQ-033 The bench SHALL cover counter wrap: perform 256 drains on channel A -> cnt (cnt_sel=0) returns to 0.
REQ-034 The bench SHALL cover reset mid-operation: assert reset with all four channels FULL and in_valid=1 -> the next cycle shows out_valid=0, OUT_x=0, cnt=0 and in_ready=1.
